// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM states for the ALU command controller.
package alu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned FLG_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_P = 1;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Opcodes above NOT are reserved and must never reach the ALU.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/alu_cmd_regfile.sv
// Small general register file: two combinational read ports, one synchronous write port.
module alu_cmd_regfile #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREG  = 4,
  localparam int unsigned IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] raddr1,
  input  logic [IDX_W-1:0] raddr2,
  output logic [WIDTH-1:0] rdata1_c,
  output logic [WIDTH-1:0] rdata2_c,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  assign rdata1_c = regs_q[raddr1];
  assign rdata2_c = regs_q[raddr2];

  // Next register contents: a single write per cycle.
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command controller sequencing an edge-triggered ALU: operands first, then the opcode edge.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREG  = 4,
  localparam int unsigned IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [IDX_W-1:0] cmd_dst,
  input  logic [IDX_W-1:0] cmd_src1,
  input  logic [IDX_W-1:0] cmd_src2,
  input  logic             cmd_use_imm,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             carry,
  input  logic             odd_parity,
  input  logic             zero,
  input  logic             overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [FLG_W-1:0] rsp_flags,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [FLG_W-1:0] flags_q, flags_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [FLG_W-1:0] rsp_flags_q, rsp_flags_d;
  logic             rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0] rf_raddr1_c;
  logic [WIDTH-1:0] rf_rdata1_c;
  logic [WIDTH-1:0] rf_rdata2_c;
  logic             rf_we_c;
  logic [FLG_W-1:0] cap_flags_c;

  alu_cmd_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (rf_raddr1_c),
    .raddr2   (cmd_src2),
    .rdata1_c (rf_rdata1_c),
    .rdata2_c (rf_rdata2_c),
    .we       (rf_we_c),
    .waddr    (dst_q),
    .wdata    (alu_out)
  );

  // Next state, operand/opcode sequencing, flag cleanup and response loading.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    alu_op_d    = alu_op_q;
    flags_d     = flags_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    rf_raddr1_c = dst_q;
    rf_we_c     = 1'b0;

    // Carry and overflow only carry meaning for ADD.
    cap_flags_c        = '0;
    cap_flags_c[FLG_C] = (op_q == OP_ADD) & carry;
    cap_flags_c[FLG_V] = (op_q == OP_ADD) & overflow;
    cap_flags_c[FLG_Z] = zero;
    cap_flags_c[FLG_P] = odd_parity;

    unique case (state_q)
      ST_IDLE: begin
        // Read port 1 serves the sources at accept and dst afterwards.
        rf_raddr1_c = cmd_src1;
        if (cmd_valid && cmd_ready_q) begin
          state_d   = ST_SETUP;
          op_d      = cmd_op;
          dst_d     = cmd_dst;
          alu_in1_d = rf_rdata1_c;
          alu_in2_d = cmd_use_imm ? cmd_imm : rf_rdata2_c;
        end
      end
      ST_SETUP: begin
        state_d  = ST_EXEC;
        alu_op_d = is_legal_op(op_q) ? op_q : OP_NOP;
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        alu_op_d    = OP_NOP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        if (!is_legal_op(op_q)) begin
          rsp_data_d  = rf_rdata1_c;
          rsp_flags_d = '0;
          rsp_err_d   = 1'b1;
        end else if (op_q == OP_NOP) begin
          rsp_data_d  = rf_rdata1_c;
          rsp_flags_d = flags_q;
        end else begin
          rf_we_c     = 1'b1;
          rsp_data_d  = alu_out;
          flags_d     = cap_flags_c;
          rsp_flags_d = cap_flags_c;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State, datapath and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      dst_q       <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_op_q    <= OP_NOP;
      flags_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_op_q    <= alu_op_d;
      flags_q     <= flags_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl driving a behavioural opcode-edge ALU.
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [1:0] cmd_dst = 2'd0, cmd_src1 = 2'd0, cmd_src2 = 2'd0;
  logic       cmd_use_imm = 1'b0;
  logic [7:0] cmd_imm = 8'h00;
  logic [7:0] alu_in1, alu_in2;
  logic [2:0] alu_op;
  logic [7:0] alu_out = 8'h00;
  logic       carry = 1'b0, odd_parity = 1'b0, zero = 1'b0, overflow = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic       rsp_err;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] flags;
    logic       err;
  } rsp_t;

  rsp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.WIDTH(8), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .carry(carry), .odd_parity(odd_parity), .zero(zero), .overflow(overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // ALU model: evaluates only when the opcode changes, holds results on NOP.
  always @(alu_op) begin : alu_model
    logic [8:0] wide;
    wide = 9'h000;
    case (alu_op)
      3'b001: begin
        wide = {1'b0, alu_in1} + {1'b0, alu_in2};
        alu_out = wide[7:0]; carry = wide[8];
        overflow = (alu_in1[7] == alu_in2[7]) && (wide[7] != alu_in1[7]);
      end
      3'b010: begin
        wide = {1'b0, alu_in1} - {1'b0, alu_in2};
        alu_out = wide[7:0]; carry = wide[8];
        overflow = (alu_in1[7] != alu_in2[7]) && (wide[7] != alu_in1[7]);
      end
      3'b011: begin alu_out = alu_in1 & alu_in2; carry = 1'b0; overflow = 1'b0; end
      3'b100: begin alu_out = alu_in1 | alu_in2; carry = 1'b0; overflow = 1'b0; end
      3'b101: begin alu_out = ~alu_in1;          carry = 1'b0; overflow = 1'b0; end
      default: ;
    endcase
    zero = (alu_out == 8'h00);
    odd_parity = ^alu_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout got none expected event", name);
  endtask

  // Monitor: one pop per response handshake (valid and ready before the next rising edge).
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_rsp");
        end else begin
          e = exp_q.pop_front();
          check("rsp_data",  32'(rsp_data),  32'(e.data));
          check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
          check("rsp_err",   32'(rsp_err),   32'(e.err));
        end
      end
    end
  end

  task automatic send_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] s1,
                          input logic [1:0] s2, input logic use_imm, input logic [7:0] imm,
                          input logic push, input logic [7:0] e_data, input logic [3:0] e_flags,
                          input logic e_err);
    rsp_t e;
    int   n;
    @(negedge clk);
    cmd_op = op; cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2;
    cmd_use_imm = use_imm; cmd_imm = imm; cmd_valid = 1'b1;
    if (push) begin
      e.data = e_data; e.flags = e_flags; e.err = e_err;
      exp_q.push_back(e);
    end
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      timeout("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Cycle-exact check of T+1..T+3 after an accept.
  task automatic chk_timing(input logic [7:0] e_in1, input logic [7:0] e_in2, input logic [2:0] e_op);
    @(negedge clk);
    check("setup_alu_op",    32'(alu_op), 0);
    check("setup_alu_in1",   32'(alu_in1), 32'(e_in1));
    check("setup_alu_in2",   32'(alu_in2), 32'(e_in2));
    check("setup_cmd_ready", 32'(cmd_ready), 0);
    check("setup_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    check("exec_alu_op",     32'(alu_op), 32'(e_op));
    check("exec_rsp_valid",  32'(rsp_valid), 0);
    @(negedge clk);
    check("resp_rsp_valid",  32'(rsp_valid), 1);
    check("resp_alu_op",     32'(alu_op), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !cmd_ready) timeout("wait_idle");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] s_data;
    logic [3:0] s_flags;
    logic       s_err;
    rsp_t       e;
    int         n;

    // Reset values while rst_n is low.
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_alu_op",    32'(alu_op), 0);
    check("rst_alu_in1",   32'(alu_in1), 0);
    check("rst_alu_in2",   32'(alu_in2), 0);
    check("rst_rsp_data",  32'(rsp_data), 0);
    check("rst_rsp_flags", 32'(rsp_flags), 0);
    check("rst_rsp_err",   32'(rsp_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", 32'(cmd_ready), 1);

    // Register setup: r1 = 12, r2 = 0x0F.
    send_cmd(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 8'd12, 1'b1, 8'd12, 4'b0000, 1'b0);
    send_cmd(OP_OR, 2'd2, 2'd0, 2'd0, 1'b1, 8'h0F, 1'b1, 8'h0F, 4'b0000, 1'b0);
    wait_idle();
    // ADD r0 = r1 + 11 with latency check.
    send_cmd(OP_ADD, 2'd0, 2'd1, 2'd0, 1'b1, 8'd11, 1'b1, 8'd23, 4'b0000, 1'b0);
    chk_timing(8'd12, 8'd11, OP_ADD);
    send_cmd(OP_NOP, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 8'd23, 4'b0000, 1'b0);
    // 0xBF + 0xBF: carry and signed overflow; src == dst reads pre-write value.
    send_cmd(OP_OR,  2'd3, 2'd3, 2'd0, 1'b1, 8'hBF, 1'b1, 8'hBF, 4'b0010, 1'b0);
    send_cmd(OP_ADD, 2'd3, 2'd3, 2'd0, 1'b1, 8'hBF, 1'b1, 8'h7E, 4'b1001, 1'b0);
    send_cmd(OP_NOP, 2'd3, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h7E, 4'b1001, 1'b0);
    wait_idle();
    // Illegal op: error, zero flags, no ALU activity, dst and captured flags untouched.
    send_cmd(3'b110, 2'd3, 2'd3, 2'd3, 1'b0, 8'h55, 1'b1, 8'h7E, 4'b0000, 1'b1);
    chk_timing(8'h7E, 8'h7E, OP_NOP);
    send_cmd(OP_NOP, 2'd3, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h7E, 4'b1001, 1'b0);
    // SUB to zero, NOT, SUB with borrow (carry suppressed), AND.
    send_cmd(OP_SUB, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00, 1'b1, 8'h00, 4'b0100, 1'b0);
    send_cmd(OP_NOT, 2'd0, 2'd2, 2'd0, 1'b1, 8'h0F, 1'b1, 8'hF0, 4'b0000, 1'b0);
    send_cmd(OP_SUB, 2'd0, 2'd1, 2'd0, 1'b1, 8'd13, 1'b1, 8'hFF, 4'b0000, 1'b0);
    send_cmd(OP_AND, 2'd2, 2'd2, 2'd0, 1'b1, 8'h3C, 1'b1, 8'h0C, 4'b0000, 1'b0);
    wait_idle();

    // Backpressure: response held 5 cycles, a pending command is ignored meanwhile.
    rsp_ready = 1'b0;
    send_cmd(OP_ADD, 2'd2, 2'd2, 2'd0, 1'b1, 8'd1, 1'b1, 8'h0D, 4'b0010, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) timeout("stall_rsp_valid");
    s_data = rsp_data; s_flags = rsp_flags; s_err = rsp_err;
    check("stall_first_data", 32'(s_data), 32'h0D);
    cmd_op = OP_NOP; cmd_dst = 2'd2; cmd_src1 = 2'd2; cmd_use_imm = 1'b0; cmd_valid = 1'b1;
    e.data = 8'h0D; e.flags = 4'b0010; e.err = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 1);
      check("stall_rsp_data",  32'(rsp_data), 32'(s_data));
      check("stall_rsp_flags", 32'(rsp_flags), 32'(s_flags));
      check("stall_rsp_err",   32'(rsp_err), 32'(s_err));
      check("stall_cmd_ready", 32'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_cmd_ready", 32'(cmd_ready), 1);
    check("post_hs_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("next_accepted_cmd_ready", 32'(cmd_ready), 0);
    check("next_accepted_alu_in1",   32'(alu_in1), 32'h0D);
    wait_idle();

    // Reset pulse during EXEC: aborted, no response, registers cleared.
    send_cmd(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'd5, 1'b0, 8'h00, 4'b0000, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_exec_alu_op", 32'(alu_op), 32'(OP_ADD));
    rst_n = 1'b0;
    #1;
    check("midrst_alu_op",    32'(alu_op), 0);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_cmd_ready", 32'(cmd_ready), 0);
    check("midrst_alu_in1",   32'(alu_in1), 0);
    repeat (2) @(negedge clk);
    check("midrst_hold_rsp_valid", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    send_cmd(OP_NOP, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h00, 4'b0000, 1'b0);
    send_cmd(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'd7,  1'b1, 8'h07, 4'b0010, 1'b0);
    send_cmd(OP_NOP, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h00, 4'b0010, 1'b0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Sequential command controller that drives the combinational ALU from the opposite side of its port list. It accepts register-based ALU commands over a valid/ready handshake and sequences the ALU's operand and opcode inputs so that every command produces an opcode change. It captures `alu_out` and the flags, writes the result into a small register file, and returns the result and the cleaned-up flags over a response handshake. It sits between an instruction source or testbench and one ALU instance.

## Interface
- `WIDTH`, 8, datapath width; must match the ALU.
- `NREG`, 4, number of general registers; the register index is `$clog2(NREG)` bits (2 at default).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  3  ALU opcode: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 NOT, 110/111 illegal.
- `cmd_dst`, `cmd_src1`, `cmd_src2`  in  2 each  register indices.
- `cmd_use_imm`  in  1  when set, `cmd_imm` replaces src2.
- `cmd_imm`  in  WIDTH  immediate operand.
- `alu_in1`, `alu_in2`  out  WIDTH  ALU operands; registered.
- `alu_op`  out  3  ALU opcode; registered.
- `alu_out`  in  WIDTH  ALU result.
- `carry`, `odd_parity`, `zero`, `overflow`  in  1 each  ALU flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  WIDTH  result value.
- `rsp_flags`  out  4  {overflow, zero, odd_parity, carry}.
- `rsp_err`  out  1  illegal opcode.

## Operation
- FSM states and transitions:
  - IDLE → SETUP on `cmd_valid && cmd_ready`.
  - SETUP → EXEC.
  - EXEC → RESP.
  - RESP → IDLE on `rsp_valid && rsp_ready`.
- Accept: in IDLE, `cmd_ready` = 1. On handshake, latch op, dst, operand values (read from the register file, or `cmd_imm` for src2 when `cmd_use_imm`), and `use_imm`.
- SETUP: drive `alu_in1`/`alu_in2` with the latched operands; `alu_op` = 000. Operands settle before the opcode edge because the ALU evaluates only on `alu_op` change.
- EXEC: `alu_op` = latched op.
  - At the EXEC→RESP edge, sample `alu_out` and the flags.
  - Write `alu_out` to reg[dst].
  - Load `rsp_data`/`rsp_flags`.
  - Return `alu_op` to 000.
- Flag cleanup, applied at capture:
  - `carry` is forwarded for ADD only, otherwise 0.
  - `overflow` is forwarded for ADD only, otherwise 0.
  - `zero` and `odd_parity` are forwarded for all legal ops.
- NOP (000): no ALU activity, so `alu_op` stays 000 through SETUP/EXEC. No register write. `rsp_data` = reg[dst]; `rsp_flags` = last captured flags; `rsp_err` = 0.
- Illegal op (110/111): handled like NOP, but `rsp_err` = 1 and `rsp_flags` = 0.
- A source register equal to dst reads the pre-write value.
- One command in flight; no pipelining.

## Timing
- Handshake accepted at edge T:
  - T+1: SETUP; operands valid, `alu_op` = 000.
  - T+2: EXEC; `alu_op` = op.
  - T+3: RESP; `rsp_valid` = 1; register written and visible.
- `rsp_valid`, `rsp_data`, `rsp_flags` and `rsp_err` are held stable until `rsp_ready`. `cmd_ready` is 0 from T+1 until the edge after the response handshake.
- Minimum spacing between accepted commands: 4 cycles, when `rsp_ready` is tied high.
- Reset values:
  - Register file, `alu_in1`/`alu_in2` = 0.
  - `alu_op` = 000.
  - `rsp_valid` = 0; `rsp_data`, `rsp_flags`, `rsp_err` = 0.
  - Captured flags = 0; state IDLE.
  - `cmd_ready` = 0 while `rst_n` is low and 1 from the first edge after deassertion.
- Reset asserted mid-operation: the command is aborted, there is no response and no register write, and all outputs take their reset values immediately (asynchronous reset).
- `cmd_valid` in non-IDLE states is ignored; the command must be held by the source.

## Structure
- Package `alu_pkg`:
  - opcode localparams (OP_NOP..OP_NOT);
  - flag bit indices (FLG_C=0, FLG_P=1, FLG_Z=2, FLG_V=3);
  - FSM state typedef;
  - `is_legal_op` function.
- Sub-module `alu_cmd_regfile`: NREG×WIDTH, two combinational read ports, one synchronous write port, async active-low reset to 0.
- Top-level `alu_cmd_ctrl` holds the FSM, operand/op registers and capture logic. The bench instantiates it with the ALU.

## Test plan
- ADD 12 + 11 to r0 (r1 = 12 via setup, immediate 11) → `rsp_data` = 23, flags V0 Z0 P0 C0; r0 = 23; `rsp_valid` at T+3.
- ADD 0xBF + 0xBF → `rsp_data` = 0x7E, C = 1, V = 1, P = 0, Z = 0.
- SUB r1 − r1 with r1 = 12 → `rsp_data` = 0, Z = 1, C = 0, V = 0; NOT immediate source 0x0F → 0xF0, P = 0.
- Illegal op 110 → `rsp_err` = 1, `rsp_flags` = 0, dst unchanged, `alu_op` stays 000 for the whole command.
- `rsp_ready` held low for 5 cycles → response fields stable, `cmd_ready` = 0 throughout, the next command is accepted one edge after the handshake.
- `rst_n` pulsed low during EXEC → no response, r[dst] = 0, `alu_op` = 000; the next command completes normally.
